conv_window_feeder: RTL and testbench

Consumer-side controller for the convolution row-buffer loader. It requests each FILTER_SIZE-row band of the image with a one-cycle `new_buffer` pulse and waits for `loaded`. It then captures the band and sweeps it column by column, emitting every FILTER_SIZE×FILTER_SIZE window over a valid/ready handshake to the MAC/filter stage. It advances band by band until all IMAGE_HEIGHT−FILTER_SIZE+1 output rows are produced, which leaves the loader's row counter wrapped back to 0 for the next frame.

---
 rtl/conv_window_feeder.sv | 163 ++++++++++++++++
 tb/tb_conv_window_feeder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
// conv_window_feeder
// Consumer-side sequencer for the convolution row-buffer loader. For each
// FILTER_SIZE-row band it pulses new_buffer and waits for loaded. It then
// captures the band and streams every FILTER_SIZE x FILTER_SIZE window,
// column by column, over a valid/ready handshake. It continues band by band
// until all IMAGE_HEIGHT-FILTER_SIZE+1 output rows have been produced.
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   start           begin a frame (sampled in IDLE only)
//   load_en         to loader, tied low
//   new_buffer      to loader, one-cycle band request
//   loaded          from loader, band valid on row_buffer_flat this cycle
//   row_buffer_flat band, row i pixel j at [(i*IMAGE_WIDTH+j)*8 +: 8]
//   window_flat     window, element (r,c) at [(r*FILTER_SIZE+c)*8 +: 8]
//   win_valid       window_flat / win_row / win_col valid
//   win_ready       downstream accepts
//   win_row         output row index (top row of the band)
//   win_col         output column index
//   busy            high whenever not IDLE
//   frame_done      one-cycle pulse after the final window transfer
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// REQ    | new_buffer pulse, requesting the band at win_row
// WAIT   | waiting for loaded; band is captured on loaded
// SWEEP  | presenting windows, one per accepted transfer
// DONE   | frame_done pulse, then back to IDLE
module conv_window_feeder #(
   parameter int IMAGE_WIDTH  = 128,
   parameter int IMAGE_HEIGHT = 128,
   parameter int FILTER_SIZE  = 3
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   output logic                                    load_en,
   output logic                                    new_buffer,
   input  logic                                    loaded,
   input  logic [FILTER_SIZE*IMAGE_WIDTH*8-1:0]    row_buffer_flat,
   output logic [FILTER_SIZE*FILTER_SIZE*8-1:0]    window_flat,
   output logic                                    win_valid,
   input  logic                                    win_ready,
   output logic [$clog2(IMAGE_HEIGHT)-1:0]         win_row,
   output logic [$clog2(IMAGE_WIDTH)-1:0]          win_col,
   output logic                                    busy,
   output logic                                    frame_done
);

   localparam int ROW_W = $clog2(IMAGE_HEIGHT);
   localparam int COL_W = $clog2(IMAGE_WIDTH);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - FILTER_SIZE);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - FILTER_SIZE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_SWEEP,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [FILTER_SIZE*IMAGE_WIDTH*8-1:0] band;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      load_en    = 1'b0;
      new_buffer = 1'b0;
      win_valid  = 1'b0;
      busy       = 1'b1;
      frame_done = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            new_buffer = 1'b1;
            state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            if (loaded) begin
               state_nxt = S_SWEEP;
            end
         end
         S_SWEEP: begin
            win_valid = 1'b1;
            if (win_ready && (win_col == LAST_COL)) begin
               state_nxt = (win_row == LAST_ROW) ? S_DONE : S_REQ;
            end
         end
         S_DONE: begin
            frame_done = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // At the end of a band win_col is left at LAST_COL; it is cleared when
   // the next band is captured, while win_valid is already low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_row <= '0;
         win_col <= '0;
         band    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  win_row <= '0;
               end
            end
            S_WAIT: begin
               if (loaded) begin
                  band    <= row_buffer_flat;
                  win_col <= '0;
               end
            end
            S_SWEEP: begin
               if (win_ready) begin
                  if (win_col != LAST_COL) begin
                     win_col <= win_col + COL_W'(1);
                  end else if (win_row != LAST_ROW) begin
                     win_row <= win_row + ROW_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Window is a pure decode of the captured band, so it holds by itself
   // whenever win_col holds (stalls) and reads 0 out of reset.
   always_comb begin
      window_flat = '0;
      for (int r = 0; r < FILTER_SIZE; r++) begin
         for (int c = 0; c < FILTER_SIZE; c++) begin
            window_flat[(r*FILTER_SIZE + c)*8 +: 8] =
               band[(r*IMAGE_WIDTH + int'(win_col) + c)*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_conv_window_feeder.sv
module tb_conv_window_feeder;

   localparam int W  = 128;
   localparam int H  = 128;
   localparam int FS = 3;
   localparam int NB = H - FS + 1;
   localparam int NX = W - FS + 1;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic                load_en;
   logic                new_buffer;
   logic                loaded;
   logic [FS*W*8-1:0]   row_buffer_flat;
   logic [FS*FS*8-1:0]  window_flat;
   logic                win_valid;
   logic                win_ready;
   logic [6:0]          win_row;
   logic [6:0]          win_col;
   logic                busy;
   logic                frame_done;

   always #5 clk = ~clk;

   conv_window_feeder #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FILTER_SIZE(FS)) dut (
      .clk(clk), .rst(rst), .start(start), .load_en(load_en),
      .new_buffer(new_buffer), .loaded(loaded), .row_buffer_flat(row_buffer_flat),
      .window_flat(window_flat), .win_valid(win_valid), .win_ready(win_ready),
      .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
   );

   int total = 0;
   int bad   = 0;
   int pe    = 0;
   logic [7:0] img [H][W];
   int rdy_mode = 0;
   int ldelay   = 0;

   int nb_frame = 0, xfer_frame = 0, done_cnt = 0;
   int nb_first = -1, nb_second = -1, valid_first = -1, done_cyc = -1;
   logic [71:0] cap0, cap1;
   bit cap0_seen = 0, cap1_seen = 0;
   int exp_row = 0, exp_col = 0;

   int w00  [9] = '{0, 1, 2, 128, 129, 130, 0, 1, 2};
   int w1125[9] = '{253, 254, 255, 125, 126, 127, 253, 254, 255};

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [71:0] pack9(input int v[9]);
      logic [71:0] p;
      for (int k = 0; k < 9; k++) p[k*8 +: 8] = v[k][7:0];
      return p;
   endfunction

   function automatic logic [71:0] exp_win(input int row, input int col);
      logic [71:0] p;
      p = 'x;
      if (row >= 0 && row + FS <= H && col >= 0 && col + FS <= W) begin
         for (int r = 0; r < FS; r++)
            for (int c = 0; c < FS; c++)
               p[(r*FS + c)*8 +: 8] = img[row + r][col + c];
      end
      return p;
   endfunction

   function automatic logic [FS*W*8-1:0] band_of(input int top);
      logic [FS*W*8-1:0] b;
      for (int r = 0; r < FS; r++)
         for (int c = 0; c < W; c++)
            b[(r*W + c)*8 +: 8] = img[top + r][c];
      return b;
   endfunction

   task automatic fill_ramp();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = 8'((r*W + c) % 256);
   endtask

   task automatic fill_random();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = 8'($urandom);
   endtask

   initial forever begin
      @(posedge clk);
      pe++;
   end

   // Loader model: keeps its own band counter, wrapping after the last band.
   int  ld_row = 0;
   bit  ld_pend = 0;
   int  ld_dly = 0;
   int  ld_bidx = 0;
   initial begin
      loaded = 1'b0;
      row_buffer_flat = '0;
      forever begin
         @(negedge clk);
         loaded = 1'b0;
         row_buffer_flat = {96{$urandom}};
         if (!rst) begin
            ld_row = 0;
            ld_pend = 0;
         end else begin
            if (ld_pend) begin
               if (ld_dly == 0) begin
                  loaded = 1'b1;
                  row_buffer_flat = band_of(ld_bidx);
                  ld_pend = 0;
               end else begin
                  ld_dly--;
               end
            end
            if (new_buffer) begin
               ld_pend = 1;
               ld_dly  = ldelay;
               ld_bidx = ld_row;
               ld_row  = (ld_row == H - FS) ? 0 : ld_row + 1;
            end
         end
      end
   end

   // Monitor / scoreboard: expected windows in raster order of output rows.
   bit prev_stall = 0, prev_valid = 0, prev_nb = 0, prev_done = 0, prev_loaded = 0;
   logic [71:0] hold_win;
   logic [13:0] hold_pos;
   int cyc;
   initial forever begin
      @(negedge clk);
      #1;
      cyc = pe + 1;
      if (!rst) begin
         exp_row = 0; exp_col = 0;
         prev_stall = 0; prev_valid = 0; prev_nb = 0; prev_done = 0; prev_loaded = 0;
         win_ready = 1'b1;
      end else begin
         win_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         check("load_en_low", load_en, 0);
         if (prev_nb) check("new_buffer_single", new_buffer, 0);
         if (new_buffer) begin
            if (nb_frame == 0) nb_first = cyc;
            if (nb_frame == 1) nb_second = cyc;
            nb_frame++;
         end
         if (win_valid && !prev_valid) begin
            check("valid_after_loaded", prev_loaded, 1);
            if (valid_first < 0) valid_first = cyc;
         end
         if (prev_stall) begin
            check("stall_valid", win_valid, 1);
            check("stall_window", window_flat, hold_win);
            check("stall_pos", {win_row, win_col}, hold_pos);
         end
         if (prev_done) check("busy_drop", busy, 0);
         if (frame_done) begin
            check("done_busy", busy, 1);
            check("done_xfers", xfer_frame, NB*NX);
            check("done_rows", exp_row, NB);
            done_cnt++;
            done_cyc = cyc;
            exp_row = 0;
            exp_col = 0;
         end
         if (win_valid && win_ready) begin
            check("xfer_pos", {win_row, win_col}, {7'(exp_row), 7'(exp_col)});
            check("xfer_window", window_flat, exp_win(exp_row, exp_col));
            if (win_row == 0 && win_col == 0) begin cap0 = window_flat; cap0_seen = 1; end
            if (win_row == 1 && win_col == 125) begin cap1 = window_flat; cap1_seen = 1; end
            xfer_frame++;
            exp_col++;
            if (exp_col == NX) begin exp_col = 0; exp_row++; end
         end
         prev_stall  = win_valid && !win_ready;
         hold_win    = window_flat;
         hold_pos    = {win_row, win_col};
         prev_valid  = win_valid;
         prev_nb     = new_buffer;
         prev_done   = frame_done;
         prev_loaded = loaded;
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic clear_stats();
      nb_frame = 0; xfer_frame = 0;
      nb_first = -1; nb_second = -1; valid_first = -1; done_cyc = -1;
      cap0_seen = 0; cap1_seen = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n0;
      n0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == n0; i++) step();
      check("frame_done_seen", done_cnt, n0 + 1);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      win_ready = 1'b1;
      fill_ramp();
      step();
      step();
      check("reset_outputs",
            {load_en, new_buffer, win_valid, busy, frame_done, win_row, win_col, window_flat}, 0);
      rst = 1'b1;

      // Frame 1: ramp image, ready tied high, start sampled at edge 10.
      clear_stats();
      while (pe < 9) step();
      pulse_start();
      wait_done(20000);
      check("lat_new_buffer", nb_first, 11);
      check("lat_second_band", nb_second, 11 + 128);
      check("lat_first_valid", valid_first, 13);
      check("lat_frame_done", done_cyc, 16139);
      check("f1_bands", nb_frame, NB);
      check("f1_xfers", xfer_frame, NB*NX);
      check("f1_first_win_seen", cap0_seen, 1);
      check("f1_first_win", cap0, pack9(w00));
      check("f1_win_1_125_seen", cap1_seen, 1);
      check("f1_win_1_125", cap1, pack9(w1125));

      // Frame 2: back to back, with a start pulse mid-frame.
      step();
      check("idle_after_done", busy, 0);
      clear_stats();
      pulse_start();
      repeat (500) step();
      pulse_start();
      wait_done(20000);
      check("f2_frames", done_cnt, 2);
      check("f2_bands", nb_frame, NB);
      check("f2_xfers", xfer_frame, NB*NX);
      check("f2_first_win", cap0, pack9(w00));

      // Frame 3: random image, 50% backpressure, loaded delayed 5 cycles.
      fill_random();
      rdy_mode = 1;
      ldelay = 5;
      step();
      clear_stats();
      pulse_start();
      wait_done(60000);
      check("f3_bands", nb_frame, NB);
      check("f3_xfers", xfer_frame, NB*NX);
      check("f3_first_win", cap0, exp_win(0, 0));
      rdy_mode = 0;
      ldelay = 0;

      // Reset during the sweep of row 40, then restart.
      step();
      clear_stats();
      pulse_start();
      begin
         bit found;
         found = 0;
         for (int i = 0; i < 10000 && !found; i++) begin
            step();
            if (win_valid && win_row == 7'd40) found = 1;
         end
         check("reached_row40", found, 1);
      end
      #1 rst = 1'b0;
      #1 check("async_reset_outputs",
               {load_en, new_buffer, win_valid, busy, frame_done, win_row, win_col, window_flat}, 0);
      step();
      step();
      rst = 1'b1;
      clear_stats();
      step();
      pulse_start();
      for (int i = 0; i < 200 && !cap0_seen; i++) step();
      check("rst_first_win_seen", cap0_seen, 1);
      check("rst_first_win", cap0, exp_win(0, 0));
      check("rst_first_band", nb_frame, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
